iq_offset_sample_buffer: RTL and testbench
==========================================

// Module: iq_offset_sample_buffer
// PURPOSE
//  Circular I/Q sample store for the timing-offset estimator. A streaming port
//  writes complex samples sequentially; a read port returns the sample at A and,
//  in dual mode, the sample at (A+OFFSET) mod DEPTH, so CP/preamble correlators
//  can fetch lagged pairs. The optional feature adds the product x[A]*conj(x[A+OFF]).
// PARAMETERS
//  DATA_W  9     bit width of each real and each imag component (two's complement)
//  DEPTH   5120  number of complex samples stored; need not be a power of two
//  ADDR_W  13    address/offset width; 2**ADDR_W >= DEPTH
// PORTS
//  clk       in   1         rising-edge clock
//  rst_n     in   1         asynchronous reset, active-low
//  wr_en     in   1         write sample at wr_ptr this cycle
//  wr_re     in   DATA_W    real part of sample to write
//  wr_im     in   DATA_W    imag part of sample to write
//  wr_ptr    out  ADDR_W    next write address
//  full      out  1         DEPTH samples have been written since reset
//  rd_req    in   1         launch one read
//  mode      in   1         0 = single read (port 1 only); 1 = dual read
//  rd_addr   in   ADDR_W    base address A
//  offset    in   ADDR_W    lag; only used when mode=1
//  rd_valid  out  1         outputs below are valid this cycle
//  rd_err    out  1         with rd_valid: illegal address or offset
//  out1_re   out  DATA_W    real part of x[A]
//  out1_im   out  DATA_W    imag part of x[A]
//  out2_re   out  DATA_W    real part of x[(A+offset) mod DEPTH]
//  out2_im   out  DATA_W    imag part of x[(A+offset) mod DEPTH]
// BEHAVIOUR
//  - Reset: wr_ptr=0, full=0, rd_valid=0, rd_err=0, all out* =0; memory not cleared.
//  - Write: on wr_en, mem[wr_ptr]<={wr_re,wr_im}; wr_ptr increments and wraps
//    from DEPTH-1 to 0. full sets on the first wrap and stays set until reset.
//    When full, new writes overwrite the oldest samples.
//  - Read pipeline (2 cycles, fully pipelined, one request per cycle):
//    S1: latch A, mode; compute B=A+offset as an ADDR_W+1 bit sum; if B>=DEPTH,
//    B-=DEPTH. err=(A>=DEPTH)|(mode&(offset>=DEPTH)).
//    S2: read mem[A] and mem[B]; rd_valid=1 exactly 2 cycles after rd_req.
//  - mode=0: out1 updates and out2 holds its previous value.
//  - rd_err=1: out1 and out2 are driven to 0. rd_valid is still asserted.
//  - Read and write to the same address in the same cycle: read-first (old
//    data is returned).
//  - offset=0 in mode 1: out2 equals out1.
//  - Reset mid-read: in-flight requests are discarded, and rd_valid stays 0
//    until a new rd_req is issued after release.
// CONFIGURATION
//  CONJ_PROD_EN defined:
//    - adds stage S3 and ports prod_re/prod_im (out, 2*DATA_W+1 bits each).
//    - prod = out1 * conj(out2): re = a*c + b*d, im = b*c - a*d, computed full
//      precision and signed.
//    - read latency becomes 3. rd_valid, rd_err and out* are delayed with prod so
//      that all of them stay aligned.
//    - mode=0 or rd_err: prod = 0. prod_* reset to 0.
//  Not defined: no product ports, no multipliers, and latency is 2.
// TESTING
//  - Reset: hold rst_n=0 mid-stream -> all outputs 0, wr_ptr=0, full=0 asynchronously.
//  - Write ramp: write 5120 samples re=i[8:0], im=-i[8:0] -> full rises on the
//    5120th write and wr_ptr=0; read A=7 mode=0 -> 2 cycles later re=7, im=-7.
//  - Wrap: mode=1, A=5100, offset=64 -> out1=x[5100], out2=x[44];
//    A=5119, offset=1 -> out2=x[0].
//  - Back-to-back: rd_req on 4 consecutive cycles with A=0..3 and offset=16 ->
//    4 consecutive rd_valid pulses, in order.
//  - Errors: A=5120 -> rd_err=1 with data 0; offset=5120 in mode 1 -> rd_err=1;
//    offset=5120 in mode 0 -> rd_err=0.
//  - CONJ_PROD_EN: x[A]=(3,4), x[B]=(1,-2), mode=1 -> prod=(-5,10) at latency 3.

Source files
------------

// File: rtl/iq_offset_sample_buffer.sv
// -----------------------------------------------------------------------------
// iq_offset_sample_buffer
//
// Circular store of complex (I/Q) samples for the timing-offset estimator.
// Samples stream in through the write port. A pipelined read port returns
// x[A] and, in dual mode, x[(A+offset) mod DEPTH]. CP/preamble correlators
// use the second sample as the lagged partner of the first.
//
// Optional feature (macro CONJ_PROD_EN):
//   Adds a third read stage that forms x[A] * conj(x[B]) at full precision.
//   The ports prod_re/prod_im carry the result, and the read latency grows
//   from 2 to 3. The default build (macro undefined) has no product ports
//   and no multipliers.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   wr_en     write {wr_re, wr_im} at wr_ptr this cycle
//   wr_re     real part of the sample to write (two's complement)
//   wr_im     imag part of the sample to write (two's complement)
//   wr_ptr    next write address (wraps DEPTH-1 -> 0)
//   full      sticky flag; set on the first pointer wrap after reset
//   rd_req    launch one read (one per cycle; no back-pressure)
//   mode      0 = single read (port 1 only), 1 = dual read
//   rd_addr   base address A
//   offset    lag added to A when mode = 1
//   rd_valid  read results below are valid this cycle
//   rd_err    with rd_valid: illegal address or offset (data forced to 0)
//   out1_re   real part of x[A]
//   out1_im   imag part of x[A]
//   out2_re   real part of x[(A+offset) mod DEPTH]
//   out2_im   imag part of x[(A+offset) mod DEPTH]
//   prod_re   (CONJ_PROD_EN) re{x[A] * conj(x[B])}
//   prod_im   (CONJ_PROD_EN) im{x[A] * conj(x[B])}
//
// Handshake: a read request is a single-cycle strobe. The read port applies
// no back-pressure, so every cycle with rd_req=1 produces exactly one
// rd_valid pulse, a fixed latency later (2 cycles, or 3 with CONJ_PROD_EN).
// Results come back in request order. rd_err only has meaning while
// rd_valid=1; it is held at 0 otherwise.
// -----------------------------------------------------------------------------
module iq_offset_sample_buffer #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 5120,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_re,
  input  logic [DATA_W-1:0] wr_im,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              full,
  input  logic              rd_req,
  input  logic              mode,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] offset,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [DATA_W-1:0] out1_re,
  output logic [DATA_W-1:0] out1_im,
  output logic [DATA_W-1:0] out2_re,
  output logic [DATA_W-1:0] out2_im
`ifdef CONJ_PROD_EN
  ,
  output logic signed [2*DATA_W:0] prod_re,
  output logic signed [2*DATA_W:0] prod_im
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // DEPTH held one bit wider, so the compare still works when 2**ADDR_W == DEPTH.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Sample memory. It has no reset: contents survive rst_n.
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {wr_re, wr_im};
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer and the sticky full flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      full   <= 1'b0;
    end else if (wr_en) begin
      if (wr_ptr == LAST_ADDR) begin
        wr_ptr <= '0;
        full   <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: address check and modular addition of the lag
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0]   sum_ab;
  logic              a_bad;
  logic              off_bad;
  logic              err_s0;
  logic [ADDR_W-1:0] b_next;

  assign sum_ab  = {1'b0, rd_addr} + {1'b0, offset};
  assign a_bad   = ({1'b0, rd_addr} >= DEPTH_X);
  assign off_bad = ({1'b0, offset}  >= DEPTH_X);
  assign err_s0  = a_bad | (mode & off_bad);
  // When A and offset are both legal, the sum is below 2*DEPTH, so one
  // conditional subtract is enough to wrap it.
  assign b_next  = ADDR_W'((sum_ab >= DEPTH_X) ? (sum_ab - DEPTH_X) : sum_ab);

  logic              s1_valid;
  logic              s1_mode;
  logic              s1_err;
  logic [ADDR_W-1:0] s1_a;
  logic [ADDR_W-1:0] s1_b;

  // Both memory indices are kept inside [0, DEPTH). Illegal or unused
  // addresses are parked at 0; their data is discarded in S2 anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_err   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= rd_req;
      if (rd_req) begin
        s1_mode <= mode;
        s1_err  <= err_s0;
        s1_a    <= a_bad ? '0 : rd_addr;
        s1_b    <= (mode && !err_s0) ? b_next : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: memory read. The write above updates mem on this same edge, so a
  // read and a write to the same address in one cycle return the old word
  // (read-first).
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0] word1;
  logic [2*DATA_W-1:0] word2;

  assign word1 = mem[s1_a];
  assign word2 = mem[s1_b];

  logic              s2_valid;
  logic              s2_err;
  logic              s2_dual_ok;
  logic [DATA_W-1:0] s2_o1_re;
  logic [DATA_W-1:0] s2_o1_im;
  logic [DATA_W-1:0] s2_o2_re;
  logic [DATA_W-1:0] s2_o2_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_err     <= 1'b0;
      s2_dual_ok <= 1'b0;
      s2_o1_re   <= '0;
      s2_o1_im   <= '0;
      s2_o2_re   <= '0;
      s2_o2_im   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_err   <= s1_valid & s1_err;
      if (s1_valid) begin
        s2_dual_ok <= s1_mode & ~s1_err;
        if (s1_err) begin
          s2_o1_re <= '0;
          s2_o1_im <= '0;
          s2_o2_re <= '0;
          s2_o2_im <= '0;
        end else begin
          s2_o1_re <= word1[2*DATA_W-1:DATA_W];
          s2_o1_im <= word1[DATA_W-1:0];
          // In single mode port 2 keeps whatever it last showed.
          if (s1_mode) begin
            s2_o2_re <= word2[2*DATA_W-1:DATA_W];
            s2_o2_im <= word2[DATA_W-1:0];
          end
        end
      end
    end
  end

`ifdef CONJ_PROD_EN
  // ---------------------------------------------------------------------------
  // S3: (a + jb) * (c - jd) = (ac + bd) + j(bc - ad), full precision.
  // Every read output is re-registered here, so data and flags stay aligned
  // with the product.
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0]   sa, sb, sc, sd;
  logic signed [2*DATA_W-1:0] m_ac, m_bd, m_bc, m_ad;
  logic signed [2*DATA_W:0]   p_re, p_im;

  assign sa   = $signed(s2_o1_re);
  assign sb   = $signed(s2_o1_im);
  assign sc   = $signed(s2_o2_re);
  assign sd   = $signed(s2_o2_im);
  assign m_ac = (2*DATA_W)'(sa) * (2*DATA_W)'(sc);
  assign m_bd = (2*DATA_W)'(sb) * (2*DATA_W)'(sd);
  assign m_bc = (2*DATA_W)'(sb) * (2*DATA_W)'(sc);
  assign m_ad = (2*DATA_W)'(sa) * (2*DATA_W)'(sd);
  assign p_re = (2*DATA_W+1)'(m_ac) + (2*DATA_W+1)'(m_bd);
  assign p_im = (2*DATA_W+1)'(m_bc) - (2*DATA_W+1)'(m_ad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      out1_re  <= '0;
      out1_im  <= '0;
      out2_re  <= '0;
      out2_im  <= '0;
      prod_re  <= '0;
      prod_im  <= '0;
    end else begin
      rd_valid <= s2_valid;
      rd_err   <= s2_err;
      out1_re  <= s2_o1_re;
      out1_im  <= s2_o1_im;
      out2_re  <= s2_o2_re;
      out2_im  <= s2_o2_im;
      if (s2_valid) begin
        // A single-mode read or an error leaves port 2 meaningless, so the
        // product is zero for it.
        prod_re <= s2_dual_ok ? p_re : '0;
        prod_im <= s2_dual_ok ? p_im : '0;
      end
    end
  end
`else
  // Without the product stage, S2 drives the ports directly.
  assign rd_valid = s2_valid;
  assign rd_err   = s2_err;
  assign out1_re  = s2_o1_re;
  assign out1_im  = s2_o1_im;
  assign out2_re  = s2_o2_re;
  assign out2_im  = s2_o2_im;

  logic unused_dual_ok;
  assign unused_dual_ok = s2_dual_ok;
`endif

endmodule

// File: tb/tb_iq_offset_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_iq_offset_sample_buffer
//
// Directed bench for iq_offset_sample_buffer. Driver tasks issue writes and
// reads. Each read pushes its expected result onto exp_q. A monitor running
// on the falling clock edge pops one entry for every rd_valid pulse and
// checks the data, the error flag and the arrival cycle.
// -----------------------------------------------------------------------------
module tb_iq_offset_sample_buffer;

  localparam int DW    = 9;
  localparam int DEPTH = 5120;
  localparam int AW    = 13;
`ifdef CONJ_PROD_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_re, wr_im;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          rd_req, mode;
  logic [AW-1:0] rd_addr, offset;
  logic          rd_valid, rd_err;
  logic [DW-1:0] out1_re, out1_im, out2_re, out2_im;
`ifdef CONJ_PROD_EN
  logic signed [2*DW:0] prod_re, prod_im;
`endif

  iq_offset_sample_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_re(wr_re), .wr_im(wr_im),
    .wr_ptr(wr_ptr), .full(full),
    .rd_req(rd_req), .mode(mode), .rd_addr(rd_addr), .offset(offset),
    .rd_valid(rd_valid), .rd_err(rd_err),
    .out1_re(out1_re), .out1_im(out1_im), .out2_re(out2_re), .out2_im(out2_im)
`ifdef CONJ_PROD_EN
    , .prod_re(prod_re), .prod_im(prod_im)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic          err;
    logic [DW-1:0] o1re, o1im, o2re, o2im;
    logic [2*DW:0] pre, pim;
    int            due;
  } exp_t;

  exp_t exp_q[$];

  int vec = 0;
  int mis = 0;

  logic [2*DW-1:0] model [DEPTH];
  int              wp    = 0;
  logic            fullm = 1'b0;
  logic [DW-1:0]   last_o2re = '0, last_o2im = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] re, input logic [DW-1:0] im);
    wr_en = 1'b1; wr_re = re; wr_im = im;
    model[wp] = {re, im};
    wp = (wp + 1) % DEPTH;
    if (wp == 0) fullm = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Present one read for one cycle and record its expected result. rd_req
  // is left high, so back-to-back calls form a burst.
  task automatic issue(input int a, input int off, input logic m);
    exp_t e;
    int   b, ia, ib, ic, id;
    rd_req = 1'b1; rd_addr = AW'(a); offset = AW'(off); mode = m;
    e = '0;
    e.err = (a >= DEPTH) || (m && off >= DEPTH);
    if (e.err) begin
      last_o2re = '0; last_o2im = '0;
    end else begin
      {e.o1re, e.o1im} = model[a];
      if (m) begin
        b = (a + off) % DEPTH;
        {last_o2re, last_o2im} = model[b];
      end
    end
    e.o2re = last_o2re; e.o2im = last_o2im;
    if (m && !e.err) begin
      ia = int'($signed(e.o1re)); ib = int'($signed(e.o1im));
      ic = int'($signed(e.o2re)); id = int'($signed(e.o2im));
      e.pre = (2*DW+1)'(ia * ic + ib * id);
      e.pim = (2*DW+1)'(ib * ic - ia * id);
    end
    e.due = cyc + LAT;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic rd(input int a, input int off, input logic m);
    issue(a, off, m);
    rd_req = 1'b0;
  endtask

  // ---------------- monitor ----------------
  exp_t got_e;
  always @(negedge clk) begin
    if (rd_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        vec++; mis++;
        $display("FAIL unexpected_rd_valid: got %b expected 0 (t=%0t)", rd_valid, $time);
      end else begin
        got_e = exp_q.pop_front();
        chk("latency_cycle", cyc, got_e.due);
        chk("rd_err",  32'(rd_err),  32'(got_e.err));
        chk("out1_re", 32'(out1_re), 32'(got_e.o1re));
        chk("out1_im", 32'(out1_im), 32'(got_e.o1im));
        chk("out2_re", 32'(out2_re), 32'(got_e.o2re));
        chk("out2_im", 32'(out2_im), 32'(got_e.o2im));
`ifdef CONJ_PROD_EN
        chk("prod_re", 32'(prod_re), 32'(got_e.pre));
        chk("prod_im", 32'(prod_im), 32'(got_e.pim));
`endif
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_err"},   32'(rd_err),   0);
    chk({tag, "_out1"},     32'({out1_re, out1_im}), 0);
    chk({tag, "_out2"},     32'({out2_re, out2_im}), 0);
    chk({tag, "_wr_ptr"},   32'(wr_ptr),   0);
    chk({tag, "_full"},     32'(full),     0);
`ifdef CONJ_PROD_EN
    chk({tag, "_prod"},     32'(prod_re) | 32'(prod_im), 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    rst_n = 1'b0; wr_en = 1'b0; wr_re = '0; wr_im = '0;
    rd_req = 1'b0; mode = 1'b0; rd_addr = '0; offset = '0;

    #3;
    chk_reset_outputs("reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Write ramp: re = i, im = -i (9-bit two's complement).
    for (int i = 0; i < DEPTH; i++) begin
      wr(DW'(i), DW'(-i));
      if (i == 2000 || i == DEPTH - 2 || i == DEPTH - 1) begin
        chk("ramp_full",   32'(full),   32'(fullm));
        chk("ramp_wr_ptr", 32'(wr_ptr), wp);
      end
    end
    chk("full_after_5120", 32'(full), 1);
    chk("wr_ptr_wrapped",  32'(wr_ptr), 0);

    // Single read of x[7] = (7, -7); port 2 still shows its reset value.
    rd(7, 0, 1'b0);
    idle(LAT);
    chk("x7_re_direct", 32'(out1_re), 32'h007);
    chk("x7_im_direct", 32'(out1_im), 32'h1F9);

    // Dual reads across the wrap boundary.
    rd(5100, 64, 1'b1);
    rd(5119, 1, 1'b1);
    rd(12, 5119, 1'b1);

    // Back-to-back burst of four reads.
    for (int a = 0; a < 4; a++) issue(a, 16, 1'b1);
    rd_req = 1'b0;

    // Error and boundary handling.
    rd(5120, 0, 1'b0);
    rd(5, 5120, 1'b1);
    rd(5, 5120, 1'b0);
    rd(10, 0, 1'b1);
    rd(300, 7, 1'b1);
    rd(301, 0, 1'b0);

    // Read-first: read x[0] while the same address is rewritten at the S2 edge.
    issue(0, 0, 1'b1);
    rd_req = 1'b0;
    wr(9'h0AA, 9'h155);
    rd(0, 0, 1'b1);
    idle(LAT + 2);

    // Reset while a read is in flight: the read must vanish.
    rd(20, 0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    last_o2re = '0; last_o2im = '0;
    wp = 0; fullm = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    idle(3);
    rst_n = 1'b1;
    idle(LAT + 3);

    // The memory keeps its contents through reset.
    rd(100, 0, 1'b0);
    // Conjugate product vector: x[0] = (3,4), x[1] = (1,-2) -> (-5, 10).
    wr(9'd3, 9'd4);
    wr(9'd1, 9'h1FE);
    chk("post_reset_wr_ptr", 32'(wr_ptr), 2);
    chk("post_reset_full",   32'(full),   0);
    rd(0, 1, 1'b1);
    rd(1, 5119, 1'b1);

    // Drain the scoreboard, with a bounded wait.
    budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); budget--;
    end
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
